// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: takes one decoded memory request, runs at most one access on
// the req/ack data port and hands the extended result to writeback.
module ysyx_23060240_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_rd_en,
    input  logic        in_wr_en,
    input  logic [2:0]  in_rd_ctrl,
    input  logic [7:0]  in_wr_ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Handshake rule for both in_* and out_*: a transfer happens on a rising
    // edge where valid and ready are both 1. The unit never drops out_valid or
    // changes out_rdata/out_err while waiting for out_ready; in_ready is 1 only
    // in IDLE, so at most one request is ever in flight.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [1:0]  r_off;
    logic [2:0]  r_rd_ctrl;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;

    logic        w_is_ld;
    logic        w_is_st;
    logic        w_ld_legal;
    logic        w_st_legal;
    logic        w_illegal;
    logic        w_misal;
    logic        w_go_bus;
    logic        w_req_err;
    logic        w_timeout;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_mask;
    logic [31:0] w_shifted;
    logic [31:0] w_ld_data;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_RESP);
    assign out_rdata = r_rdata;
    assign out_err   = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;

    // The wait counter only matters when a timeout is configured.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_cnt == 32'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Classify the incoming request: legal bus access, error, or pass-through.
    always_comb begin
        w_is_ld    = in_rd_en & ~in_wr_en;
        w_is_st    = in_wr_en & ~in_rd_en;
        w_ld_legal = (in_rd_ctrl >= 3'd1) && (in_rd_ctrl <= 3'd5);
        w_st_legal = (in_wr_ctrl >= 8'h01) && (in_wr_ctrl <= 8'h03);
        w_illegal  = (in_rd_en & in_wr_en) | (w_is_ld & ~w_ld_legal) | (w_is_st & ~w_st_legal);
        w_misal    = 1'b0;
        if (w_is_ld) begin
            case (in_rd_ctrl)
                3'd3, 3'd4: w_misal = in_addr[0];
                3'd5:       w_misal = (in_addr[1:0] != 2'b00);
                default:    w_misal = 1'b0;
            endcase
        end else if (w_is_st) begin
            case (in_wr_ctrl)
                8'h02:   w_misal = in_addr[0];
                8'h03:   w_misal = (in_addr[1:0] != 2'b00);
                default: w_misal = 1'b0;
            endcase
        end
        w_go_bus  = (w_is_ld | w_is_st) & ~w_illegal & ~w_misal;
        w_req_err = (in_rd_en | in_wr_en) & ~w_go_bus;
    end

    // Place store data on every lane it may land in and strobe the target lanes.
    always_comb begin
        w_st_data = in_wdata;
        w_st_mask = 4'b1111;
        case (in_wr_ctrl)
            8'h01: begin
                w_st_data = {4{in_wdata[7:0]}};
                w_st_mask = 4'b0001 << in_addr[1:0];
            end
            8'h02: begin
                w_st_data = {2{in_wdata[15:0]}};
                w_st_mask = 4'b0011 << in_addr[1:0];
            end
            default: ;
        endcase
    end

    // Pull the addressed byte/half/word out of the returned word and extend it.
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        w_ld_data = 32'd0;
        case (r_rd_ctrl)
            3'd1:    w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd2:    w_ld_data = {24'd0, w_shifted[7:0]};
            3'd3:    w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4:    w_ld_data = {16'd0, w_shifted[15:0]};
            3'd5:    w_ld_data = w_shifted;
            default: w_ld_data = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: errors and pass-through skip the bus entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = w_go_bus ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture the request on accept, drive the bus, capture the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_off       <= 2'd0;
            r_rd_ctrl   <= 3'd0;
            r_cnt       <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_off     <= in_addr[1:0];
                        r_rd_ctrl <= in_rd_ctrl;
                        r_cnt     <= 32'd0;
                        if (w_go_bus) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_st;
                            r_mem_addr  <= {in_addr[31:2], 2'b00};
                            r_mem_wdata <= w_is_st ? w_st_data : 32'd0;
                            r_mem_wmask <= w_is_st ? w_st_mask : 4'd0;
                        end else begin
                            r_rdata <= 32'd0;
                            r_err   <= w_req_err;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        // An ack in the final allowed cycle still completes normally.
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_mem_we ? 32'd0 : w_ld_data;
                        r_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= 32'd0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Self-checking bench for the load/store unit, with a byte-level reference model.
module tb_ysyx_23060240_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_rd_en;
  logic        in_wr_en;
  logic [2:0]  in_rd_ctrl;
  logic [7:0]  in_wr_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  ysyx_23060240_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd_en(in_rd_en), .in_wr_en(in_wr_en),
    .in_rd_ctrl(in_rd_ctrl), .in_wr_ctrl(in_wr_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // clock
  always #5 clk = ~clk;

  // Reference model: access size/sign from the control code, alignment as
  // address modulo size, lanes and extension by plain arithmetic.
  function automatic void model(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  rc,
    input  logic [7:0]  wc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output bit          go,
    output logic        eerr,
    output logic        ewe,
    output logic [31:0] ewdata,
    output logic [3:0]  emask,
    output logic [31:0] erdata
  );
    int size;
    bit sgn;
    int off;
    longint val;
    longint lim;
    go = 0; eerr = 1'b0; ewe = 1'b0; ewdata = '0; emask = '0; erdata = '0;
    size = 0; sgn = 0;
    off = int'(addr % 32'd4);
    if (!rd && !wr) return;
    if (rd && wr) begin eerr = 1'b1; return; end
    if (rd) begin
      case (rc)
        3'd1: begin size = 1; sgn = 1; end
        3'd2: begin size = 1; sgn = 0; end
        3'd3: begin size = 2; sgn = 1; end
        3'd4: begin size = 2; sgn = 0; end
        3'd5: begin size = 4; sgn = 0; end
        default: size = 0;
      endcase
    end else begin
      case (wc)
        8'h01: size = 1;
        8'h02: size = 2;
        8'h03: size = 4;
        default: size = 0;
      endcase
    end
    if (size == 0 || (off % size) != 0) begin eerr = 1'b1; return; end
    go = 1;
    ewe = wr;
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        ewdata[8*k +: 8] = wdata[8*(k % size) +: 8];
        emask[k] = (k >= off) && (k < off + size);
      end
    end else begin
      lim = longint'(1) << (8 * size);
      val = (longint'(rword) >> (8 * off)) % lim;
      if (sgn && val >= lim / 2) val = val - lim;
      erdata = 32'(val);
    end
  endfunction

  // Drive one request, play the memory with 'waits' idle cycles before ack,
  // hold off writeback for 'hold' cycles, then complete the handshake.
  task automatic run_txn(
    input string       name,
    input logic        rd,
    input logic        wr,
    input logic [2:0]  rc,
    input logic [7:0]  wc,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rword,
    input int          waits,
    input int          hold
  );
    bit go;
    logic eerr, ewe;
    logic [31:0] ewd, erd;
    logic [3:0] emask;
    model(rd, wr, rc, wc, addr, wdata, rword, go, eerr, ewe, ewd, emask, erd);

    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_idle got=%b exp=1", name, in_ready); end

    in_valid = 1'b1; in_rd_en = rd; in_wr_en = wr; in_rd_ctrl = rc; in_wr_ctrl = wc;
    in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    // inputs change after accept; the unit must have captured them already
    in_valid = 1'b0; in_rd_en = 1'($urandom); in_wr_en = 1'($urandom);
    in_rd_ctrl = 3'($urandom); in_wr_ctrl = 8'($urandom); in_addr = $urandom; in_wdata = $urandom;

    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_busy got=%b exp=0", name, in_ready); end

    if (go) begin
      for (int i = 0; i <= waits; i++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== ewe || mem_addr !== {addr[31:2], 2'b00} ||
            mem_wmask !== emask || (ewe && mem_wdata !== ewd) || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s bus cyc=%0d got req=%b we=%b addr=%h wd=%h mask=%b ov=%b exp req=1 we=%b addr=%h wd=%h mask=%b ov=0",
                   name, i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid,
                   ewe, {addr[31:2], 2'b00}, ewd, emask);
        end
        if (i == waits) begin mem_ack = 1'b1; mem_rdata = rword; end
        else mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
    end

    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req_after got=%b exp=0", name, mem_req); end
    checks++;
    if (out_valid !== 1'b1 || out_err !== eerr || out_rdata !== erd) begin
      errors++;
      $display("FAIL %s result got v=%b err=%b rdata=%h exp v=1 err=%b rdata=%h",
               name, out_valid, out_err, out_rdata, eerr, erd);
    end

    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom);
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== eerr || out_rdata !== erd || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold cyc=%0d got v=%b err=%b rdata=%h rdy=%b exp v=1 err=%b rdata=%h rdy=0",
                 name, i, out_valid, out_err, out_rdata, in_ready, eerr, erd);
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake got v=%b rdy=%b exp v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || out_rdata !== 32'd0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
        mem_wmask !== 4'd0) begin
      errors++;
      $display("FAIL reset got rdy=%b v=%b err=%b rd=%h req=%b we=%b a=%h wd=%h m=%b exp rdy=1 rest=0",
               in_ready, out_valid, out_err, out_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    run_txn("lw_zero_wait", 1, 0, 3'd5, 8'h00, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn("lb",           1, 0, 3'd1, 8'h00, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 0);
    run_txn("lbu",          1, 0, 3'd2, 8'h00, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2, 0);
    run_txn("lh",           1, 0, 3'd3, 8'h00, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 0);
    run_txn("lhu",          1, 0, 3'd4, 8'h00, 32'h8000_0000, 32'h0, 32'h1234_F00D, 0, 0);
  endtask

  task automatic test_stores();
    run_txn("sb", 0, 1, 3'd0, 8'h01, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0, 0);
    run_txn("sh", 0, 1, 3'd0, 8'h02, 32'h8000_0002, 32'h0000_1234, 32'h0, 1, 0);
    run_txn("sw", 0, 1, 3'd7, 8'h03, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 0, 0);
  endtask

  task automatic test_errors();
    run_txn("lw_misaligned", 1, 0, 3'd5, 8'h00, 32'h8000_0002, 32'h0, 32'h0, 0, 0);
    run_txn("lh_misaligned", 1, 0, 3'd3, 8'h00, 32'h8000_0001, 32'h0, 32'h0, 0, 0);
    run_txn("sh_misaligned", 0, 1, 3'd0, 8'h02, 32'h8000_0003, 32'h0, 32'h0, 0, 0);
    run_txn("both_enables",  1, 1, 3'd5, 8'h03, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn("bad_rd_ctrl",   1, 0, 3'd6, 8'h00, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn("bad_wr_ctrl",   0, 1, 3'd0, 8'h04, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn("pass_through",  0, 0, 3'd5, 8'h03, 32'h8000_0000, 32'h5555_5555, 32'h0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("bp_load",  1, 0, 3'd1, 8'h00, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 5);
    run_txn("bp_error", 1, 0, 3'd5, 8'h00, 32'h8000_0001, 32'h0, 32'h0, 0, 5);
  endtask

  task automatic test_timeout();
    int high;
    // ack in the last allowed wait cycle still completes normally
    run_txn("ack_at_limit", 1, 0, 3'd5, 8'h00, 32'h8000_0010, 32'h0, 32'h1357_9BDF, 3, 0);

    in_valid = 1'b1; in_rd_en = 1'b1; in_wr_en = 1'b0; in_rd_ctrl = 3'd5; in_wr_ctrl = 8'h00;
    in_addr = 32'h8000_0020; in_wdata = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    high = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req === 1'b1) high++;
      if (out_valid === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++;
    if (high != 4) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=4", high); end
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result got v=%b err=%b rdata=%h req=%b exp v=1 err=1 rdata=0 req=0",
               out_valid, out_err, out_rdata, mem_req);
    end
    // a late ack while waiting on writeback changes nothing
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'd0) begin
      errors++;
      $display("FAIL late_ack_resp got v=%b err=%b rdata=%h exp v=1 err=1 rdata=0", out_valid, out_err, out_rdata);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_handshake got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_req();
    in_valid = 1'b1; in_rd_en = 1'b0; in_wr_en = 1'b1; in_rd_ctrl = 3'd0; in_wr_ctrl = 8'h03;
    in_addr = 32'h8000_0040; in_wdata = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_wait cyc=%0d mem_req got=%b exp=1", i, mem_req); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 ||
        out_rdata !== 32'd0 || mem_wmask !== 4'd0 || mem_addr !== 32'd0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_req got req=%b rdy=%b v=%b err=%b rd=%h m=%b a=%h we=%b exp req=0 rdy=1 rest=0",
               mem_req, in_ready, out_valid, out_err, out_rdata, mem_wmask, mem_addr, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_ack_idle cyc=%0d got v=%b req=%b rdy=%b exp v=0 req=0 rdy=1", i, out_valid, mem_req, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_sw", 0, 1, 3'd0, 8'h03, 32'h8000_0100, 32'hA1B2_C3D4, 32'h0, 0, 0);
    run_txn("b2b_lw", 1, 0, 3'd5, 8'h00, 32'h8000_0100, 32'h0, 32'hA1B2_C3D4, 0, 0);
    run_txn("b2b_err", 0, 1, 3'd0, 8'h03, 32'h8000_0101, 32'h0, 32'h0, 0, 0);
    run_txn("b2b_lhu", 1, 0, 3'd4, 8'h00, 32'h8000_0102, 32'h0, 32'hFEDC_BA98, 0, 0);
  endtask

  task automatic test_random();
    int kind;
    logic rd, wr;
    logic [2:0] rc;
    logic [7:0] wc;
    logic [31:0] addr;
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 9);
      rc = 3'($urandom); wc = 8'($urandom); addr = $urandom;
      rd = 1'b0; wr = 1'b0;
      if (kind <= 3) begin rd = 1'b1; rc = 3'($urandom_range(1, 5)); end
      else if (kind <= 6) begin wr = 1'b1; wc = 8'($urandom_range(1, 3)); end
      else if (kind == 8) begin rd = 1'b1; wr = 1'b1; end
      else if (kind == 9) begin rd = 1'($urandom); wr = 1'($urandom); wc = 8'($urandom_range(0, 7)); end
      if (kind <= 6 && $urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_txn("random", rd, wr, rc, wc, addr, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_rd_en = 1'b0; in_wr_en = 1'b0;
    in_rd_ctrl = '0; in_wr_ctrl = '0; out_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
